// File: rtl/quadrilatero_burst_sched_if.sv
// Handshake bundle between requesters, shared row ports and the burst scheduler.
// abort_o exists only when QUADRILATERO_BURST_WDOG_EN is defined.
interface quadrilatero_burst_sched_if #(
  parameter int unsigned NUM_REQ   = 8,
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned N_ROWS    = 4
);
  localparam int unsigned RW   = $clog2(NUM_REQ);
  localparam int unsigned ROWW = $clog2(N_ROWS);

  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ-1:0]        row_ready_i;
  logic [NUM_PORTS-1:0]      port_ready_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic [NUM_PORTS-1:0]      port_busy_o;
  logic [NUM_PORTS*RW-1:0]   port_owner_o;
  logic [NUM_PORTS*ROWW-1:0] port_row_o;
  logic [NUM_PORTS-1:0]      beat_o;
  logic [NUM_REQ-1:0]        done_o;
`ifdef QUADRILATERO_BURST_WDOG_EN
  logic [NUM_REQ-1:0]        abort_o;
`endif

  modport master (
    output req_i, row_ready_i, port_ready_i,
    input  gnt_o, port_busy_o, port_owner_o, port_row_o, beat_o, done_o
`ifdef QUADRILATERO_BURST_WDOG_EN
    , input abort_o
`endif
  );

  modport slave (
    input  req_i, row_ready_i, port_ready_i,
    output gnt_o, port_busy_o, port_owner_o, port_row_o, beat_o, done_o
`ifdef QUADRILATERO_BURST_WDOG_EN
    , output abort_o
`endif
  );
endinterface

// File: rtl/quadrilatero_burst_sched.sv
// Round-robin scheduler handing N_ROWS-row bursts from NUM_REQ requesters to NUM_PORTS row ports.
// Define QUADRILATERO_BURST_WDOG_EN to add a per-port stall watchdog and the abort_o output.
module quadrilatero_burst_sched #(
  parameter int unsigned NUM_REQ     = 8,
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned N_ROWS      = 4,
  parameter int unsigned WDOG_CYCLES = 16
) (
  input logic                       clk_i,
  input logic                       rst_ni,
  quadrilatero_burst_sched_if.slave bus
);

  localparam int unsigned RW   = $clog2(NUM_REQ);
  localparam int unsigned ROWW = $clog2(N_ROWS);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } port_state_e;

  port_state_e          state_q [NUM_PORTS];
  port_state_e          state_d [NUM_PORTS];
  logic [RW-1:0]        owner_q [NUM_PORTS];
  logic [RW-1:0]        owner_d [NUM_PORTS];
  logic [ROWW-1:0]      row_q   [NUM_PORTS];
  logic [ROWW-1:0]      row_d   [NUM_PORTS];
  logic [RW-1:0]        rr_q;
  logic [RW-1:0]        rr_d;

  logic [NUM_REQ-1:0]   gntVec;
  logic [NUM_REQ-1:0]   candMask;
  logic [NUM_REQ-1:0]   doneVec;
  logic [NUM_PORTS-1:0] busyVec;
  logic [NUM_PORTS-1:0] beatVec;

  logic [NUM_PORTS-1:0] allocValid;
  logic [RW-1:0]        allocOwner [NUM_PORTS];
  logic [RW-1:0]        lastAlloc;
  logic                 anyAlloc;
  logic                 portFound;
  int unsigned          scanIdx;

`ifdef QUADRILATERO_BURST_WDOG_EN
  localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);

  logic [WW-1:0]        wdog_q [NUM_PORTS];
  logic [WW-1:0]        wdog_d [NUM_PORTS];
  logic [NUM_REQ-1:0]   abortVec;
`else
  // The limit only matters with the watchdog built in; zero would be meaningless either way.
  if (WDOG_CYCLES == 0) begin : g_wdog_limit_invalid
  end
`endif

  // A requester is granted exactly while some port in BURST names it as owner.
  always_comb begin
    gntVec  = '0;
    busyVec = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (state_q[p] == BURST) begin
        busyVec[p]          = 1'b1;
        gntVec[owner_q[p]]  = 1'b1;
      end
    end
  end

  assign candMask = bus.req_i & ~gntVec;

  // Scan requesters from rr_q with wrap; the k-th candidate takes the k-th idle port.
  always_comb begin
    allocValid = '0;
    anyAlloc   = 1'b0;
    lastAlloc  = '0;
    portFound  = 1'b0;
    scanIdx    = 0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      allocOwner[p] = '0;
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scanIdx = 32'(rr_q) + i;
      if (scanIdx >= NUM_REQ) begin
        scanIdx = scanIdx - NUM_REQ;
      end
      portFound = 1'b0;
      if (candMask[RW'(scanIdx)]) begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
          if (!portFound && (state_q[p] == IDLE) && !allocValid[p]) begin
            allocValid[p] = 1'b1;
            allocOwner[p] = RW'(scanIdx);
            portFound     = 1'b1;
            anyAlloc      = 1'b1;
            lastAlloc     = RW'(scanIdx);
          end
        end
      end
    end
  end

  // Per-port next state: claim on allocation, advance a row per beat, retire on the last row.
  always_comb begin
    if (anyAlloc) begin
      rr_d = (lastAlloc == RW'(NUM_REQ - 1)) ? '0 : lastAlloc + 1'b1;
    end else begin
      rr_d = rr_q;
    end
    beatVec = '0;
    doneVec = '0;
`ifdef QUADRILATERO_BURST_WDOG_EN
    abortVec = '0;
`endif
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      state_d[p] = state_q[p];
      owner_d[p] = owner_q[p];
      row_d[p]   = row_q[p];
`ifdef QUADRILATERO_BURST_WDOG_EN
      wdog_d[p]  = wdog_q[p];
`endif
      case (state_q[p])
        IDLE: begin
          if (allocValid[p]) begin
            state_d[p] = BURST;
            owner_d[p] = allocOwner[p];
            row_d[p]   = '0;
`ifdef QUADRILATERO_BURST_WDOG_EN
            wdog_d[p]  = '0;
`endif
          end
        end
        BURST: begin
          beatVec[p] = bus.port_ready_i[p] & bus.row_ready_i[owner_q[p]];
          if (beatVec[p]) begin
`ifdef QUADRILATERO_BURST_WDOG_EN
            wdog_d[p] = '0;
`endif
            if (row_q[p] == ROWW'(N_ROWS - 1)) begin
              doneVec[owner_q[p]] = 1'b1;
              state_d[p]          = IDLE;
              owner_d[p]          = '0;
              row_d[p]            = '0;
            end else begin
              row_d[p] = row_q[p] + 1'b1;
            end
          end
`ifdef QUADRILATERO_BURST_WDOG_EN
          else if (wdog_q[p] == WW'(WDOG_CYCLES - 1)) begin
            abortVec[owner_q[p]] = 1'b1;
            state_d[p]           = IDLE;
            owner_d[p]           = '0;
            row_d[p]             = '0;
            wdog_d[p]            = '0;
          end else begin
            wdog_d[p] = wdog_q[p] + 1'b1;
          end
`endif
        end
        default: begin
          state_d[p] = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        state_q[p] <= IDLE;
        owner_q[p] <= '0;
        row_q[p]   <= '0;
`ifdef QUADRILATERO_BURST_WDOG_EN
        wdog_q[p]  <= '0;
`endif
      end
    end else begin
      rr_q <= rr_d;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        state_q[p] <= state_d[p];
        owner_q[p] <= owner_d[p];
        row_q[p]   <= row_d[p];
`ifdef QUADRILATERO_BURST_WDOG_EN
        wdog_q[p]  <= wdog_d[p];
`endif
      end
    end
  end

  // Owner and row fields read as zero whenever the port is idle.
  always_comb begin
    bus.port_owner_o = '0;
    bus.port_row_o   = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (state_q[p] == BURST) begin
        bus.port_owner_o[p*RW +: RW]   = owner_q[p];
        bus.port_row_o[p*ROWW +: ROWW] = row_q[p];
      end
    end
  end

  assign bus.gnt_o       = gntVec;
  assign bus.port_busy_o = busyVec;
  assign bus.beat_o      = beatVec;
  assign bus.done_o      = doneVec;
`ifdef QUADRILATERO_BURST_WDOG_EN
  assign bus.abort_o     = abortVec;
`endif

endmodule

// File: tb/tb_quadrilatero_burst_sched.sv
// Scoreboard bench for quadrilatero_burst_sched: expected completions are queued as requests are issued.
// Covers the QUADRILATERO_BURST_WDOG_EN build as well as the default one.
module tb_quadrilatero_burst_sched;

  localparam int NUM_REQ   = 8;
  localparam int NUM_PORTS = 2;
  localparam int N_ROWS    = 4;
  localparam int WDOG      = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  quadrilatero_burst_sched_if #(
    .NUM_REQ  (NUM_REQ),
    .NUM_PORTS(NUM_PORTS),
    .N_ROWS   (N_ROWS)
  ) bus ();

  quadrilatero_burst_sched #(
    .NUM_REQ    (NUM_REQ),
    .NUM_PORTS  (NUM_PORTS),
    .N_ROWS     (N_ROWS),
    .WDOG_CYCLES(WDOG)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [NUM_REQ-1:0] pending;
  int expDone[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One cycle of stimulus: inputs change just after the falling edge, outputs settle 1 ns later.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] rowReady, input logic [NUM_PORTS-1:0] portReady);
    @(negedge clk);
    bus.row_ready_i  = rowReady;
    bus.port_ready_i = portReady;
    bus.req_i        = pending;
    #1;
  endtask

  // Requesters drop their request in the cycle their burst ends.
  task automatic retireDone();
    for (int r = 0; r < NUM_REQ; r++) begin
      if (bus.done_o[r]) pending[r] = 1'b0;
`ifdef QUADRILATERO_BURST_WDOG_EN
      if (bus.abort_o[r]) pending[r] = 1'b0;
`endif
    end
    bus.req_i = pending;
  endtask

  task automatic runUntilIdle(input string tag, input int maxCycles);
    int n;
    n = 0;
    do begin
      applyStimulus('1, '1);
      retireDone();
      n++;
    end while (((pending != 0) || (bus.port_busy_o != 0)) && (n < maxCycles));
    checkOutput(tag, 32'((pending != 0) || (bus.port_busy_o != 0)), 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_gnt"},   bus.gnt_o, 0);
    checkOutput({tag, "_busy"},  bus.port_busy_o, 0);
    checkOutput({tag, "_owner"}, bus.port_owner_o, 0);
    checkOutput({tag, "_row"},   bus.port_row_o, 0);
    checkOutput({tag, "_beat"},  bus.beat_o, 0);
    checkOutput({tag, "_done"},  bus.done_o, 0);
`ifdef QUADRILATERO_BURST_WDOG_EN
    checkOutput({tag, "_abort"}, bus.abort_o, 0);
`endif
  endtask

  task automatic pulseReset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetOutputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Completion monitor: every done_o bit must match the head of the expected queue.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (bus.done_o[r]) begin
          if (expDone.size() == 0) checkOutput("done_unexpected", r, 32'hFF);
          else checkOutput("done_order", r, expDone.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    pending          = '0;
    bus.req_i        = '0;
    bus.row_ready_i  = '0;
    bus.port_ready_i = '0;

    // Outputs stay quiet in reset even with every requester asking.
    @(negedge clk);
    bus.req_i = '1;
    #1;
    checkResetOutputs("rst");
    bus.req_i = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single burst: one-cycle grant latency, rows 0..3, done on the last row, grant gone after.
    pending = 8'h01;
    expDone.push_back(0);
    applyStimulus('1, '1);
    checkOutput("t1_gnt_latency", bus.gnt_o, 0);
    retireDone();
    for (int k = 0; k < N_ROWS; k++) begin
      applyStimulus('1, '1);
      checkOutput("t1_gnt", bus.gnt_o, 8'h01);
      checkOutput("t1_beat", bus.beat_o, 2'b01);
      checkOutput("t1_row", bus.port_row_o[1:0], k);
      checkOutput("t1_done", bus.done_o, (k == N_ROWS - 1) ? 8'h01 : 8'h00);
      retireDone();
    end
    applyStimulus('1, '1);
    checkOutput("t1_gnt_drop", bus.gnt_o, 0);
    checkOutput("t1_busy_drop", bus.port_busy_o, 0);

    // All requesters at once from rr=0: pairs (0,1), (2,3), (4,5), (6,7).
    pulseReset("t2_rst");
    pending = 8'hFF;
    for (int r = 0; r < NUM_REQ; r++) expDone.push_back(r);
    applyStimulus('1, '1);
    retireDone();
    for (int k = 0; k < N_ROWS; k++) begin
      applyStimulus('1, '1);
      if (k == 0) begin
        checkOutput("t2_gnt", bus.gnt_o, 8'h03);
        checkOutput("t2_owner01", bus.port_owner_o, 6'h08);
      end
      checkOutput("t2_row", bus.port_row_o, (k << 2) | k);
      checkOutput("t2_beat", bus.beat_o, 2'b11);
      retireDone();
    end
    applyStimulus('1, '1);
    checkOutput("t2_gap_gnt", bus.gnt_o, 0);
    retireDone();
    applyStimulus('1, '1);
    checkOutput("t2_owner23", bus.port_owner_o, 6'h1A);
    checkOutput("t2_gnt23", bus.gnt_o, 8'h0C);
    retireDone();
    runUntilIdle("t2_timeout", 60);

    // rr=0 -> 4,5 taken, rr=6; then 7 and 0 wrap around, rr=1; then 1 before 0.
    pending = 8'h30;
    expDone.push_back(4);
    expDone.push_back(5);
    applyStimulus('1, '1);
    retireDone();
    applyStimulus('1, '1);
    checkOutput("t3_owner45", bus.port_owner_o, 6'h2C);
    retireDone();
    runUntilIdle("t3a_timeout", 20);
    pending = 8'h81;
    expDone.push_back(0);
    expDone.push_back(7);
    applyStimulus('1, '1);
    retireDone();
    applyStimulus('1, '1);
    checkOutput("t3_owner_wrap", bus.port_owner_o, 6'h07);
    checkOutput("t3_gnt_wrap", bus.gnt_o, 8'h81);
    retireDone();
    runUntilIdle("t3b_timeout", 20);
    pending = 8'h03;
    expDone.push_back(0);
    expDone.push_back(1);
    applyStimulus('1, '1);
    retireDone();
    applyStimulus('1, '1);
    checkOutput("t3_owner_rr1", bus.port_owner_o, 6'h01);
    retireDone();
    runUntilIdle("t3c_timeout", 20);

    // Requester 2 stalls on row 1 for 10 cycles, then finishes.
    pending = 8'h04;
    expDone.push_back(2);
    applyStimulus('1, '1);
    retireDone();
    applyStimulus('1, '1);
    checkOutput("t4_row0", bus.port_row_o[1:0], 0);
    retireDone();
    for (int k = 0; k < 10; k++) begin
      applyStimulus(8'hFB, '1);
      checkOutput("t4_stall_row", bus.port_row_o[1:0], 1);
      checkOutput("t4_stall_beat", bus.beat_o, 0);
      checkOutput("t4_stall_done", bus.done_o, 0);
      retireDone();
    end
    runUntilIdle("t4_timeout", 20);

    // Request withdrawn at row 1 still completes.
    pending = 8'h08;
    expDone.push_back(3);
    applyStimulus('1, '1);
    retireDone();
    applyStimulus('1, '1);
    retireDone();
    applyStimulus('1, '1);
    checkOutput("t5_row1", bus.port_row_o[1:0], 1);
    pending[3] = 1'b0;
    bus.req_i  = pending;
    applyStimulus('1, '1);
    checkOutput("t5_still_gnt", bus.gnt_o, 8'h08);
    retireDone();
    runUntilIdle("t5_timeout", 20);

    // Reset mid-burst: outputs clear at once, no done; a grant follows the first edge after release.
    pending = 8'h10;
    applyStimulus('1, '1);
    retireDone();
    applyStimulus('1, '1);
    retireDone();
    applyStimulus('1, '1);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("t6_rst");
    pending   = 8'h20;
    bus.req_i = pending;
    expDone.push_back(5);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus('1, '1);
    checkOutput("t6_gnt_after_rst", bus.gnt_o, 8'h20);
    checkOutput("t6_owner_after_rst", bus.port_owner_o, 6'h05);
    retireDone();
    runUntilIdle("t6_timeout", 20);

    // Port-side stall on row 1.
    pending = 8'h40;
    applyStimulus('1, '1);
    retireDone();
    applyStimulus('1, '1);
    retireDone();
`ifdef QUADRILATERO_BURST_WDOG_EN
    for (int k = 1; k <= WDOG; k++) begin
      applyStimulus('1, 2'b10);
      checkOutput("t7_wdog_abort", bus.abort_o, (k == WDOG) ? 8'h40 : 8'h00);
      checkOutput("t7_wdog_done", bus.done_o, 0);
      checkOutput("t7_wdog_busy", bus.port_busy_o[0], 1);
      retireDone();
    end
    applyStimulus('1, '1);
    checkOutput("t7_idle_busy", bus.port_busy_o, 0);
    checkOutput("t7_idle_gnt", bus.gnt_o, 0);
    checkOutput("t7_idle_owner", bus.port_owner_o, 0);
    retireDone();
`else
    expDone.push_back(6);
    for (int k = 0; k < 20; k++) begin
      applyStimulus('1, 2'b10);
      checkOutput("t7_hold_busy", bus.port_busy_o, 2'b01);
      checkOutput("t7_hold_row", bus.port_row_o[1:0], 1);
      checkOutput("t7_hold_owner", bus.port_owner_o[2:0], 6);
      checkOutput("t7_hold_beat", bus.beat_o, 0);
      retireDone();
    end
    runUntilIdle("t7_timeout", 20);
`endif

    applyStimulus('1, '1);
    checkOutput("sb_empty", expDone.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
